// File: rtl/spi_master_arbiter.sv
// Round-robin front end that shares one SPI_Master among three requesters.
// It latches each granted request, pulses load/start, times the frame and returns the read byte.
module spi_master_arbiter #(
  parameter int XFER_CYCLES  = 16,
  parameter int GUARD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [23:0] req_wdata,
  input  logic [5:0]  req_addr,
  input  logic [5:0]  req_mode,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic [7:0]  rdata,
  output logic        err,
  output logic        busy,
  output logic        m_load,
  output logic        m_start,
  output logic [7:0]  m_data_to_write,
  output logic [1:0]  m_slave_address,
  output logic        m_cpol,
  output logic        m_cpha,
  input  logic [7:0]  m_data_read
);

  localparam int CW = $clog2(XFER_CYCLES + GUARD_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, LOAD, XFER, CAPTURE, GUARD, ERR} state_t;

  state_t      state;
  logic [1:0]  ptr;
  logic [2:0]  owner;
  logic [CW-1:0] count;
  logic [7:0]  cfg_wdata;
  logic [1:0]  cfg_addr;
  logic [1:0]  cfg_mode;

  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [2:0]  grant_onehot;
  logic [1:0]  next_ptr;
  logic [7:0]  sel_wdata;
  logic [1:0]  sel_addr;
  logic [1:0]  sel_mode;
  int          cand;

  // The SPI_Master only ever sees the latched configuration, never the live request inputs.
  assign m_data_to_write = cfg_wdata;
  assign m_slave_address = cfg_addr;
  assign m_cpol          = cfg_mode[1];
  assign m_cpha          = cfg_mode[0];

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 0;
    for (int i = 0; i < 3; i++) begin
      cand = (int'(ptr) + i) % 3;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = 2'(cand);
      end
    end
    grant_onehot = 3'b001 << grant_idx;
    next_ptr     = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    sel_wdata    = req_wdata[int'(grant_idx) * 8 +: 8];
    sel_addr     = req_addr[int'(grant_idx) * 2 +: 2];
    sel_mode     = req_mode[int'(grant_idx) * 2 +: 2];
  end

  // Pulse outputs default low each cycle so every ack/done/load/start is exactly one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      owner     <= 3'd0;
      count     <= '0;
      cfg_wdata <= 8'd0;
      cfg_addr  <= 2'd0;
      cfg_mode  <= 2'd0;
      ack       <= 3'd0;
      done      <= 3'd0;
      rdata     <= 8'd0;
      err       <= 1'b0;
      busy      <= 1'b0;
      m_load    <= 1'b0;
      m_start   <= 1'b0;
    end else begin
      ack     <= 3'd0;
      done    <= 3'd0;
      m_load  <= 1'b0;
      m_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cfg_wdata <= sel_wdata;
            cfg_addr  <= sel_addr;
            cfg_mode  <= sel_mode;
            owner     <= grant_onehot;
            ptr       <= next_ptr;
            busy      <= 1'b1;
            ack       <= grant_onehot;
            if (sel_addr == 2'd3) begin
              state <= ERR;
              done  <= grant_onehot;
              err   <= 1'b1;
            end else begin
              state   <= LOAD;
              m_load  <= 1'b1;
              m_start <= 1'b1;
            end
          end
        end
        LOAD: begin
          state <= XFER;
          // Modes 2/3 skip the first clock edge, so the frame needs one extra cycle.
          count <= CW'(XFER_CYCLES) + CW'(cfg_mode[1]);
        end
        XFER: begin
          if (count <= CW'(1)) begin
            state <= CAPTURE;
            done  <= owner;
            rdata <= m_data_read;
            err   <= 1'b0;
          end else begin
            count <= count - CW'(1);
          end
        end
        CAPTURE: begin
          state <= GUARD;
          count <= CW'(GUARD_CYCLES);
        end
        GUARD: begin
          if (count <= CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - CW'(1);
          end
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: single-request vector table plus rotation, reset and dropped-request sequences.
// A tiny slave model presents each slave's byte only once its frame has had time to complete.
module tb_spi_master_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_wdata;
  logic [5:0]  req_addr;
  logic [5:0]  req_mode;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic        m_load;
  logic        m_start;
  logic [7:0]  m_data_to_write;
  logic [1:0]  m_slave_address;
  logic        m_cpol;
  logic        m_cpha;
  logic [7:0]  m_data_read;

  logic [7:0]  slave_byte [4];
  int          fcnt;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    int         idx;
    logic [7:0] wdata;
    logic [1:0] addr;
    logic [1:0] mode;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs [5];

  spi_master_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_wdata(req_wdata),
    .req_addr(req_addr),
    .req_mode(req_mode),
    .ack(ack),
    .done(done),
    .rdata(rdata),
    .err(err),
    .busy(busy),
    .m_load(m_load),
    .m_start(m_start),
    .m_data_to_write(m_data_to_write),
    .m_slave_address(m_slave_address),
    .m_cpol(m_cpol),
    .m_cpha(m_cpha),
    .m_data_read(m_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame progress counter: data_read only becomes the slave's byte after a full frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt <= 0;
    else if (m_load) fcnt <= 1;
    else if (fcnt != 0 && fcnt < 100) fcnt <= fcnt + 1;
  end

  assign m_data_read = (fcnt >= 16 + int'(m_cpol)) ? slave_byte[m_slave_address] : 8'h00;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input int which, input int limit, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && ack != 3'd0) || (which == 1 && done != 3'd0) || (which == 2 && !busy)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: no event within %0d cycles", name, limit);
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] w, input logic [1:0] a, input logic [1:0] m);
    req_wdata[k*8 +: 8] = w;
    req_addr[k*2 +: 2]  = a;
    req_mode[k*2 +: 2]  = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bit ok;
    int ack_cyc;
    int done_cyc;
    int loads;
    bit stable;
    logic [11:0] cfg;
    @(negedge clk);
    set_req(v.idx, v.wdata, v.addr, v.mode);
    req[v.idx] = 1'b1;
    wait_for(0, 10, "vec_ack_wait", ok);
    if (!ok) begin
      req = 3'd0;
      return;
    end
    ack_cyc    = cyc;
    req[v.idx] = 1'b0;
    cfg = {v.wdata, v.addr, v.mode};
    check_output("vec_ack_onehot", ack, 32'(3'b001 << v.idx));
    check_output("vec_load_start", {m_load, m_start}, {2{!v.exp_err}});
    check_output("vec_config", {m_data_to_write, m_slave_address, m_cpol, m_cpha}, cfg);
    if (v.exp_err) begin
      check_output("err_done_with_ack", done, 32'(3'b001 << v.idx));
      check_output("err_flag", err, 1);
      check_output("err_rdata_kept", rdata, v.exp_rdata);
      wait_for(2, 5, "err_idle_wait", ok);
      if (ok) check_output("err_busy_drop", cyc - ack_cyc, 1);
    end else begin
      stable = 1'b1;
      loads  = 1;
      ok     = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if ({m_data_to_write, m_slave_address, m_cpol, m_cpha} != cfg) stable = 1'b0;
        if (m_load || m_start) loads++;
        if (done != 3'd0) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("[TB] FAIL vec_done_wait: no done within 40 cycles");
        return;
      end
      done_cyc = cyc;
      check_output("vec_latency", done_cyc - ack_cyc, v.exp_lat);
      check_output("vec_done_onehot", done, 32'(3'b001 << v.idx));
      check_output("vec_rdata", rdata, v.exp_rdata);
      check_output("vec_err_clear", err, 0);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if ({m_data_to_write, m_slave_address, m_cpol, m_cpha} != cfg) stable = 1'b0;
        if (m_load || m_start) loads++;
        if (!busy) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("[TB] FAIL vec_idle_wait: busy stuck high");
      end else begin
        check_output("vec_guard_len", cyc - done_cyc, 3);
      end
      check_output("vec_config_stable", stable, 1);
      check_output("vec_single_load", loads, 1);
    end
  endtask

  initial begin
    bit ok;
    int last_ack;
    int n_ack0;
    int n_ack1;
    int exp_order [4];
    int exp_gap [4];
    logic [7:0] exp_rd [4];

    rst_n = 1'b0;
    req = 3'd0;
    req_wdata = 24'd0;
    req_addr = 6'd0;
    req_mode = 6'd0;
    slave_byte[0] = 8'hBA;
    slave_byte[1] = 8'hA7;
    slave_byte[2] = 8'h3E;
    slave_byte[3] = 8'hFF;

    vecs[0] = '{idx: 0, wdata: 8'hA5, addr: 2'd0, mode: 2'b00, exp_rdata: 8'hBA, exp_err: 1'b0, exp_lat: 17};
    vecs[1] = '{idx: 1, wdata: 8'hC2, addr: 2'd1, mode: 2'b10, exp_rdata: 8'hA7, exp_err: 1'b0, exp_lat: 18};
    vecs[2] = '{idx: 2, wdata: 8'h99, addr: 2'd3, mode: 2'b00, exp_rdata: 8'hA7, exp_err: 1'b1, exp_lat: 0};
    vecs[3] = '{idx: 2, wdata: 8'h5C, addr: 2'd2, mode: 2'b11, exp_rdata: 8'h3E, exp_err: 1'b0, exp_lat: 18};
    vecs[4] = '{idx: 0, wdata: 8'h0F, addr: 2'd1, mode: 2'b01, exp_rdata: 8'hA7, exp_err: 1'b0, exp_lat: 17};

    repeat (3) @(negedge clk);
    check_output("reset_outputs",
                 {ack, done, rdata, err, busy, m_load, m_start, m_data_to_write, m_slave_address, m_cpol, m_cpha}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) apply_stimulus(vecs[v]);

    // Rotation with all three requesting: order 0,1,2,0 from a fresh pointer.
    do_reset();
    set_req(0, 8'h11, 2'd0, 2'b01);
    set_req(1, 8'h22, 2'd1, 2'b11);
    set_req(2, 8'h33, 2'd2, 2'b00);
    exp_order = '{0, 1, 2, 0};
    exp_gap   = '{0, 21, 22, 21};
    exp_rd    = '{8'hBA, 8'hA7, 8'h3E, 8'hBA};
    req = 3'b111;
    last_ack = 0;
    for (int n = 0; n < 4; n++) begin
      wait_for(0, 40, "rot_ack_wait", ok);
      if (!ok) break;
      if (n == 3) req = 3'd0;
      check_output("rot_ack_order", ack, 32'(3'b001 << exp_order[n]));
      if (n > 0) check_output("rot_ack_gap", cyc - last_ack, exp_gap[n]);
      last_ack = cyc;
      wait_for(1, 40, "rot_done_wait", ok);
      if (!ok) break;
      check_output("rot_rdata", rdata, exp_rd[n]);
    end
    req = 3'd0;
    wait_for(2, 10, "rot_idle_wait", ok);

    // Reset five cycles into XFER abandons the frame at once.
    @(negedge clk);
    set_req(0, 8'h5A, 2'd0, 2'b00);
    req = 3'b001;
    wait_for(0, 10, "rst_ack_wait", ok);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_output("midreset_outputs",
                    {ack, done, rdata, err, busy, m_load, m_start, m_data_to_write, m_slave_address, m_cpol, m_cpha}, 0);
    set_req(1, 8'h6B, 2'd1, 2'b00);
    req = 3'b011;
    repeat (2) @(negedge clk);
    check_output("midreset_no_done", {done, busy}, 0);
    rst_n = 1'b1;
    wait_for(0, 10, "postreset_ack0", ok);
    if (ok) check_output("postreset_first_grant", ack, 3'b001);
    req[0] = 1'b0;
    wait_for(0, 40, "postreset_ack1", ok);
    if (ok) check_output("postreset_second_grant", ack, 3'b010);
    req[1] = 1'b0;
    wait_for(2, 40, "postreset_idle", ok);

    // A req[0] glitch between edges is never sampled; only req[1] is served.
    @(posedge clk);
    #1 req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    req[1] = 1'b1;
    n_ack0 = 0;
    n_ack1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack[0]) n_ack0++;
      if (ack[1]) begin
        n_ack1++;
        req[1] = 1'b0;
      end
    end
    req = 3'd0;
    check_output("drop_req0_never_acked", n_ack0, 0);
    check_output("drop_req1_acked_once", n_ack1, 1);
    wait_for(2, 40, "drop_idle", ok);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
